// File: rtl/acia_pkg.sv
// rtl/acia_pkg.sv - shared definitions for the 6850 ACIA polling master
package acia_pkg;

  typedef enum logic [2:0] {
    MRST   = 3'd0,
    CFG    = 3'd1,
    GAP    = 3'd2,
    POLL   = 3'd3,
    DECIDE = 3'd4,
    RXRD   = 3'd5,
    RXCAP  = 3'd6,
    TXWR   = 3'd7
  } state_t;

  localparam logic RS_CTRL = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int RXF = 0;
  localparam int TXE = 1;
  localparam int FE  = 4;
  localparam int OVR = 5;
  localparam int IRQ = 7;

  localparam logic [7:0] MRST_CODE = 8'h03;

endpackage

// File: rtl/acia_master.sv
// rtl/acia_master.sv - polls a 6850 ACIA and bridges its data register to tx/rx byte streams
module acia_master #(
  parameter logic [7:0] CTRL_WORD = 8'h15,
  parameter int         POLL_GAP  = 15
) (
  input  logic       clk,
  input  logic       rst,
  output logic       cs,
  output logic       we,
  output logic       rs,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       irq,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err,
  input  logic       err_clr
);
  import acia_pkg::*;

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP);

  state_t        state;
  state_t        state_nx;
  logic          started;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    tx_hold;
  logic          rx_sel;
  logic          tx_sel;

  // bus_rdata holds the status byte during DECIDE; receive wins over transmit
  assign rx_sel   = bus_rdata[RXF] && !rx_valid;
  assign tx_sel   = !rx_sel && bus_rdata[TXE] && tx_valid;
  assign tx_ready = (state == DECIDE) && tx_sel;

  always_comb begin
    state_nx = state;
    case (state)
      MRST:    if (started) state_nx = CFG;
      CFG:     state_nx = GAP;
      // gap_cnt counts idle cycles still owed, this one included
      GAP:     if (irq || gap_cnt <= GW'(1)) state_nx = POLL;
      POLL:    state_nx = DECIDE;
      DECIDE:  state_nx = rx_sel ? RXRD : (tx_sel ? TXWR : GAP);
      RXRD:    state_nx = RXCAP;
      RXCAP:   state_nx = GAP;
      TXWR:    state_nx = GAP;
      default: state_nx = MRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MRST;
      started  <= 1'b0;
      gap_cnt  <= '0;
      tx_hold  <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      started <= 1'b1;
      state   <= state_nx;

      if (state_nx == GAP && state != GAP)
        gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);

      if (tx_ready)
        tx_hold <= tx_data;

      if (state == RXCAP) begin
        rx_data  <= bus_rdata;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (state == DECIDE && (bus_rdata[FE] || bus_rdata[OVR]))
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

  // started keeps the bus quiet while rst is held even though state already reads MRST
  always_comb begin
    cs        = 1'b0;
    we        = 1'b0;
    rs        = RS_CTRL;
    bus_wdata = 8'h00;
    if (started) begin
      case (state)
        MRST: begin
          cs        = 1'b1;
          we        = 1'b1;
          bus_wdata = MRST_CODE;
        end
        CFG: begin
          cs        = 1'b1;
          we        = 1'b1;
          bus_wdata = CTRL_WORD;
        end
        POLL: cs = 1'b1;
        RXRD: begin
          cs = 1'b1;
          rs = RS_DATA;
        end
        TXWR: begin
          cs        = 1'b1;
          we        = 1'b1;
          rs        = RS_DATA;
          bus_wdata = tx_hold;
        end
        default: cs = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_acia_master.sv
// tb/tb_acia_master.sv - randomized self-checking bench for acia_master with a behavioural 6850
module tb_acia_master;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       we;
  logic       rs;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       irq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       err;
  logic       err_clr;

  int vectors;
  int miscompares;

  // behavioural ACIA: status byte set by the tests, rxf drops once the data register is read
  logic [7:0] m_status;
  logic [7:0] m_rx;
  int         rd_count;
  int         rd_mark;
  logic [7:0] wr_log[$];

  acia_master dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .rs(rs), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .irq(irq), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cs && !we)
      bus_rdata <= rs ? m_rx : {m_status[7:1], m_status[0] && (rd_count == rd_mark)};
    if (cs && !we && rs)
      rd_count <= rd_count + 1;
    if (cs && we && rs)
      wr_log.push_back(bus_wdata);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic bit cond(input int kind);
    case (kind)
      0:       return cs && !we && !rs;
      1:       return cs && !we && rs;
      2:       return tx_ready;
      3:       return cs && we && rs;
      4:       return err;
      default: return rx_valid;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (cond(kind)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // park at the first GAP cycle after a status poll so stale status cannot leak into the next test
  task automatic sync_gap();
    bit ok;
    wait_for(0, 60, ok);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cs, we, rs, bus_wdata} !== 11'h0) begin
      miscompares++; $display("FAIL reset_bus got %h expected 000", {cs, we, rs, bus_wdata});
    end
    vectors++;
    if ({tx_ready, rx_valid, rx_data, err} !== 11'h0) begin
      miscompares++; $display("FAIL reset_flags got %h expected 000", {tx_ready, rx_valid, rx_data, err});
    end
  endtask

  task automatic test_startup();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cs, we, rs, bus_wdata} !== {3'b110, 8'h03}) begin
      miscompares++; $display("FAIL startup_mrst got %h expected 603", {cs, we, rs, bus_wdata});
    end
    @(negedge clk);
    vectors++;
    if ({cs, we, rs, bus_wdata} !== {3'b110, 8'h15}) begin
      miscompares++; $display("FAIL startup_cfg got %h expected 615", {cs, we, rs, bus_wdata});
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vectors++;
      if (cs !== 1'b0) begin
        miscompares++; $display("FAIL startup_gap cycle %0d cs got %b expected 0", i, cs);
      end
    end
    @(negedge clk);
    vectors++;
    if ({cs, we, rs} !== 3'b100) begin
      miscompares++; $display("FAIL startup_poll got %b expected 100", {cs, we, rs});
    end
  endtask

  task automatic test_tx();
    bit         ok;
    int         base;
    logic [7:0] b;
    logic [7:0] q[$];
    sync_gap();
    base     = wr_log.size();
    m_status = 8'h02;
    for (int i = 0; i < 6; i++) begin
      b        = 8'($urandom);
      tx_data  = (i == 0) ? 8'hA5 : b;
      tx_valid = 1'b1;
      wait_for(2, 60, ok);
      vectors++;
      if (!ok) begin
        miscompares++; $display("FAIL tx_ready_timeout byte %0d got 0 expected 1", i);
      end else begin
        q.push_back(tx_data);
        @(negedge clk);
        vectors++;
        if ({cs, we, rs, bus_wdata, tx_ready} !== {3'b111, q[q.size()-1], 1'b0}) begin
          miscompares++;
          $display("FAIL tx_write byte %0d got %h expected %h", i, {cs, we, rs, bus_wdata, tx_ready}, {3'b111, q[q.size()-1], 1'b0});
        end
      end
    end
    tx_valid = 1'b0;
    repeat (50) @(negedge clk);
    m_status = 8'h00;
    vectors++;
    if (wr_log.size() - base !== 6) begin
      miscompares++; $display("FAIL tx_write_count got %0d expected 6", wr_log.size() - base);
    end
    for (int i = 0; i < q.size() && base + i < wr_log.size(); i++) begin
      vectors++;
      if (wr_log[base+i] !== q[i]) begin
        miscompares++; $display("FAIL tx_log_%0d got %h expected %h", i, wr_log[base+i], q[i]);
      end
    end
  endtask

  task automatic test_rx_priority();
    bit ok;
    int base;
    sync_gap();
    base     = wr_log.size();
    rx_ready = 1'b0;
    m_rx     = 8'h5A;
    rd_mark  = rd_count;
    m_status = 8'h03;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    wait_for(1, 60, ok);
    vectors++;
    if (!ok || wr_log.size() != base) begin
      miscompares++; $display("FAIL rx_first got read=%b writes=%0d expected read=1 writes=0", ok, wr_log.size() - base);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin
      miscompares++; $display("FAIL rx_capture got %h expected 15a", {rx_valid, rx_data});
    end
    wait_for(2, 60, ok);
    @(negedge clk);
    tx_valid = 1'b0;
    vectors++;
    if (!ok || {cs, we, rs, bus_wdata} !== {3'b111, 8'hC3}) begin
      miscompares++; $display("FAIL tx_after_rx got %h expected 7c3", {cs, we, rs, bus_wdata});
    end
  endtask

  task automatic test_rx_hold();
    bit         ok;
    int         rc;
    logic [7:0] q[$];
    sync_gap();
    m_rx     = 8'h77;
    rd_mark  = rd_count;
    m_status = 8'h01;
    rc       = rd_count;
    repeat (60) @(negedge clk);
    vectors++;
    if (rd_count !== rc || {rx_valid, rx_data} !== {1'b1, 8'h5A}) begin
      miscompares++; $display("FAIL rx_hold got reads=%0d data=%h expected reads=0 data=15a", rd_count - rc, {rx_valid, rx_data});
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++; $display("FAIL rx_pop got %b expected 0", rx_valid);
    end
    wait_for(1, 60, ok);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (!ok || {rx_valid, rx_data} !== {1'b1, 8'h77}) begin
      miscompares++; $display("FAIL rx_next got %h expected 177", {rx_valid, rx_data});
    end
    for (int i = 0; i < 5; i++) begin
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      q.push_back(8'($urandom));
      m_rx     = q[i];
      rd_mark  = rd_count;
      wait_for(5, 60, ok);
      vectors++;
      if (!ok || rx_data !== q[i]) begin
        miscompares++; $display("FAIL rx_rand_%0d got %b/%h expected 1/%h", i, ok, rx_data, q[i]);
      end
    end
    rx_ready = 1'b1;
    m_status = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_err();
    bit ok;
    sync_gap();
    m_status = 8'h33;
    rd_mark  = rd_count;
    wait_for(4, 60, ok);
    m_status = 8'h00;
    repeat (40) @(negedge clk);
    vectors++;
    if (!ok || err !== 1'b1) begin
      miscompares++; $display("FAIL err_sticky got %b expected 1", err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL err_clear got %b expected 0", err);
    end
    sync_gap();
    m_status = 8'h10;
    err_clr  = 1'b1;
    wait_for(0, 60, ok);
    @(negedge clk);
    @(negedge clk);
    m_status = 8'h00;
    vectors++;
    if (!ok || err !== 1'b1) begin
      miscompares++; $display("FAIL err_set_wins got %b expected 1", err);
    end
    @(negedge clk);
    err_clr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL err_clr_after got %b expected 0", err);
    end
  endtask

  task automatic test_rst_irq();
    bit ok;
    sync_gap();
    m_rx     = 8'hE1;
    rd_mark  = rd_count;
    m_status = 8'h01;
    wait_for(1, 60, ok);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (!ok || {cs, we, rs, bus_wdata, rx_valid, rx_data} !== 20'h0) begin
      miscompares++; $display("FAIL rst_mid got %h expected 00000", {cs, we, rs, bus_wdata, rx_valid, rx_data});
    end
    rst      = 1'b0;
    m_status = 8'h00;
    @(negedge clk);
    vectors++;
    if ({cs, we, rs, bus_wdata} !== {3'b110, 8'h03}) begin
      miscompares++; $display("FAIL rst_mrst got %h expected 603", {cs, we, rs, bus_wdata});
    end
    @(negedge clk);
    repeat (5) @(negedge clk);
    vectors++;
    if (cs !== 1'b0) begin
      miscompares++; $display("FAIL irq_pre_gap got %b expected 0", cs);
    end
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    vectors++;
    if ({cs, we, rs} !== 3'b100) begin
      miscompares++; $display("FAIL irq_poll got %b expected 100", {cs, we, rs});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    irq         = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    rx_ready    = 1'b0;
    err_clr     = 1'b0;
    m_status    = 8'h00;
    m_rx        = 8'h00;
    rd_count    = 0;
    rd_mark     = 0;
    bus_rdata   = 8'h00;
    test_reset();
    test_startup();
    test_tx();
    test_rx_priority();
    test_rx_hold();
    test_err();
    test_rst_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
